fetch: RTL and testbench

- Instruction fetch stage of the 5-stage RV32I pipeline.
- Owns the fetch PC and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Drives the IF/ID register consumed by the decode stage (instruction, valid, PC, next PC) and honours the decode hold.
- Absorbs redirects from execute (taken branch, jal, jalr) and a sticky halt on break retirement; a 1-entry skid buffer preserves responses returned while decode holds.

---
 rtl/fetch_if.sv | 31 +++
 rtl/fetch.sv | 229 ++++++++++++++++++++++
 tb/tb_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
//   Instruction-memory bus between the fetch stage and a synchronous
//   instruction memory with a one-cycle read latency.
//
//   Signals
//     imem_ren    read enable (drives o_imem_ren of the fetch stage)
//     imem_raddr  32-bit word address, bits [1:0] always 0 (o_imem_raddr)
//     imem_rdata  read data, valid the cycle after imem_ren=1 (i_imem_rdata)
//
//   Modports
//     master  fetch side: drives the request, receives the data
//     slave   memory side: receives the request, returns the data
// -----------------------------------------------------------------------------
interface fetch_if;
    logic        imem_ren;
    logic [31:0] imem_raddr;
    logic [31:0] imem_rdata;

    modport master (
        output imem_ren,
        output imem_raddr,
        input  imem_rdata
    );

    modport slave (
        input  imem_ren,
        input  imem_raddr,
        output imem_rdata
    );
endinterface

// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch
//   Instruction fetch stage of a 5-stage RV32I pipeline.
//   Owns the fetch PC, issues reads to a 1-cycle-latency instruction memory,
//   and drives the IF/ID register consumed by decode. A 1-entry skid buffer
//   keeps a response that returns while decode holds. Redirects from execute
//   flush everything in flight; a retired break sets a sticky halt.
//
//   Optional feature (macro FETCH_MISALIGN_TRAP_EN):
//     defined   - a redirect to a target with bits [1:0] != 0 flushes, then
//                 delivers one trap entry (o_vld=1, o_trap=1, o_pc=target,
//                 o_inst=NOP_INST) and halts fetching.
//     undefined - the low target bits are cleared and o_trap is tied to 0.
//
//   Parameters
//     RESET_VEC  fetch PC loaded on reset
//     NOP_INST   instruction driven on o_inst while o_vld is low
//
//   Ports
//     i_clk          clock, rising edge
//     i_rst_n        asynchronous active-low reset
//     imem           instruction memory bus (fetch_if.master)
//     i_hold         decode hold: IF/ID must keep its value
//     i_redirect     control-flow redirect from execute
//     i_redirect_pc  redirect target
//     i_halt         break retired: stop fetching (sticky until reset)
//     o_vld          IF/ID instruction valid
//     o_inst         IF/ID instruction
//     o_pc           IF/ID instruction PC
//     o_nxt_pc       IF/ID PC+4
//     o_trap         IF/ID misaligned-fetch trap
// -----------------------------------------------------------------------------
module fetch #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    fetch_if.master     imem,
    input  logic        i_hold,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_vld,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_nxt_pc,
    output logic        o_trap
);

    // Fetch PC and the single outstanding memory request
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic        rsp_vld_reg,  rsp_vld_next;
    logic [31:0] rsp_pc_reg,   rsp_pc_next;

    // Skid entry holding a response that arrived while decode held
    logic        skid_vld_reg,  skid_vld_next;
    logic [31:0] skid_inst_reg, skid_inst_next;
    logic [31:0] skid_pc_reg,   skid_pc_next;

    logic        halt_reg, halt_next;

    // IF/ID register
    logic        vld_reg,    vld_next;
    logic [31:0] inst_reg,   inst_next;
    logic [31:0] pc_reg,     pc_next;
    logic [31:0] nxt_pc_reg, nxt_pc_next;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        skid_trap_reg, skid_trap_next;
    logic        trap_reg,      trap_next;
    logic        redirect_misaligned;
`endif

    logic        issue;
    logic [31:0] redirect_pc_aligned;

    assign redirect_pc_aligned = i_redirect_pc & ~32'h0000_0003;

    // With the skid empty a held response can still be parked, so only a
    // hold coinciding with a returning response blocks the issue. With the
    // skid full, any hold blocks it: a new response would have nowhere to go.
    always_comb begin
        issue = i_rst_n && !halt_reg && !i_redirect &&
                (skid_vld_reg ? !i_hold : !(i_hold && rsp_vld_reg));
    end

    assign imem.imem_ren   = issue;
    assign imem.imem_raddr = fetch_pc_reg;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_misaligned = (i_redirect_pc[1:0] != 2'b00);
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        fetch_pc_next  = fetch_pc_reg;
        rsp_vld_next   = 1'b0;
        rsp_pc_next    = rsp_pc_reg;
        skid_vld_next  = skid_vld_reg;
        skid_inst_next = skid_inst_reg;
        skid_pc_next   = skid_pc_reg;
        halt_next      = halt_reg | i_halt;
        vld_next       = vld_reg;
        inst_next      = inst_reg;
        pc_next        = pc_reg;
        nxt_pc_next    = nxt_pc_reg;
`ifdef FETCH_MISALIGN_TRAP_EN
        skid_trap_next = skid_trap_reg;
        trap_next      = trap_reg;
`endif

        if (issue) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
            rsp_vld_next  = 1'b1;
            rsp_pc_next   = fetch_pc_reg;
        end

        if (i_redirect) begin
            // Flush: drop in-flight data and the skid, bubble IF/ID.
            fetch_pc_next = redirect_pc_aligned;
            rsp_vld_next  = 1'b0;
            skid_vld_next = 1'b0;
            vld_next      = 1'b0;
            inst_next     = NOP_INST;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_next     = 1'b0;
            // The trap entry is parked in the skid so it drains into IF/ID
            // on the next un-held cycle, exactly like a held response.
            // Halting here keeps the stage from fetching past the fault.
            if (redirect_misaligned) begin
                skid_vld_next  = 1'b1;
                skid_inst_next = NOP_INST;
                skid_pc_next   = i_redirect_pc;
                skid_trap_next = 1'b1;
                halt_next      = 1'b1;
            end
`endif
        end else if (!i_hold) begin
            if (skid_vld_reg) begin
                vld_next      = 1'b1;
                inst_next     = skid_inst_reg;
                pc_next       = skid_pc_reg;
                nxt_pc_next   = skid_pc_reg + 32'd4;
                skid_vld_next = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                trap_next     = skid_trap_reg;
`endif
            end else if (rsp_vld_reg) begin
                vld_next    = 1'b1;
                inst_next   = imem.imem_rdata;
                pc_next     = rsp_pc_reg;
                nxt_pc_next = rsp_pc_reg + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
                trap_next   = 1'b0;
`endif
            end else begin
                vld_next  = 1'b0;
                inst_next = NOP_INST;
`ifdef FETCH_MISALIGN_TRAP_EN
                trap_next = 1'b0;
`endif
            end
        end else if (rsp_vld_reg && !skid_vld_reg) begin
            // Decode is holding: park the returning response.
            skid_vld_next  = 1'b1;
            skid_inst_next = imem.imem_rdata;
            skid_pc_next   = rsp_pc_reg;
`ifdef FETCH_MISALIGN_TRAP_EN
            skid_trap_next = 1'b0;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_reg  <= RESET_VEC;
            rsp_vld_reg   <= 1'b0;
            rsp_pc_reg    <= 32'd0;
            skid_vld_reg  <= 1'b0;
            skid_inst_reg <= 32'd0;
            skid_pc_reg   <= 32'd0;
            halt_reg      <= 1'b0;
            vld_reg       <= 1'b0;
            inst_reg      <= NOP_INST;
            pc_reg        <= 32'd0;
            nxt_pc_reg    <= 32'd0;
        end else begin
            fetch_pc_reg  <= fetch_pc_next;
            rsp_vld_reg   <= rsp_vld_next;
            rsp_pc_reg    <= rsp_pc_next;
            skid_vld_reg  <= skid_vld_next;
            skid_inst_reg <= skid_inst_next;
            skid_pc_reg   <= skid_pc_next;
            halt_reg      <= halt_next;
            vld_reg       <= vld_next;
            inst_reg      <= inst_next;
            pc_reg        <= pc_next;
            nxt_pc_reg    <= nxt_pc_next;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            skid_trap_reg <= 1'b0;
            trap_reg      <= 1'b0;
        end else begin
            skid_trap_reg <= skid_trap_next;
            trap_reg      <= trap_next;
        end
    end

    assign o_trap = trap_reg;
`else
    assign o_trap = 1'b0;
`endif

    assign o_vld    = vld_reg;
    assign o_inst   = inst_reg;
    assign o_pc     = pc_reg;
    assign o_nxt_pc = nxt_pc_reg;

endmodule

// File: tb/tb_fetch.sv
// -----------------------------------------------------------------------------
// tb_fetch
//   Directed bench for the fetch stage. A behavioural 1-cycle instruction
//   memory returns inst_of(addr). Every instruction decode is expected to
//   consume is pushed to a scoreboard in advance; a negedge monitor pops and
//   compares whenever IF/ID is valid and not held or flushed.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_hold = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'd0;
    logic        i_halt = 1'b0;
    logic        o_vld;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic [31:0] o_nxt_pc;
    logic        o_trap;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] nxt;
        logic        trap;
    } exp_t;
    exp_t sb[$];

    fetch_if imem_bus ();

    fetch dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .imem          (imem_bus.master),
        .i_hold        (i_hold),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_halt        (i_halt),
        .o_vld         (o_vld),
        .o_inst        (o_inst),
        .o_pc          (o_pc),
        .o_nxt_pc      (o_nxt_pc),
        .o_trap        (o_trap)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_1234;
    endfunction

    // Instruction memory: data valid the cycle after the read enable.
    always @(posedge i_clk) begin
        imem_bus.imem_rdata <= imem_bus.imem_ren ? inst_of(imem_bus.imem_raddr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_pc(input logic [31:0] pc);
        sb.push_back({pc, inst_of(pc), pc + 32'd4, 1'b0});
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    // Checks the combinational request of the current cycle after inputs settle.
    task automatic chk_issue(input string tag, input logic ren, input logic [31:0] addr);
        #1;
        chk({tag, "_ren"}, {31'd0, imem_bus.imem_ren}, {31'd0, ren});
        if (ren) chk({tag, "_raddr"}, imem_bus.imem_raddr, addr);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_vld"},  {31'd0, o_vld}, 32'd0);
        chk({tag, "_inst"}, o_inst, NOP);
        chk({tag, "_pc"},   o_pc, 32'd0);
        chk({tag, "_nxt"},  o_nxt_pc, 32'd0);
        chk({tag, "_trap"}, {31'd0, o_trap}, 32'd0);
        chk({tag, "_ren"},  {31'd0, imem_bus.imem_ren}, 32'd0);
    endtask

    // Scoreboard monitor: IF/ID is consumed at the coming edge when valid,
    // not held and not flushed by a redirect.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            chk("skid_rsp_overlap", {31'd0, dut.rsp_vld_reg & dut.skid_vld_reg}, 32'd0);
            if (o_vld && !i_hold && !i_redirect) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL sb_underflow: observed pc=%h expected no entry", o_pc);
                end
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_pc", o_pc, e.pc);
                    chk("sb_inst", o_inst, e.inst);
                    chk("sb_nxt", o_nxt_pc, e.nxt);
                    chk("sb_trap", {31'd0, o_trap}, {31'd0, e.trap});
                    $display("consumed pc=%h inst=%h nxt=%h trap=%0d", o_pc, o_inst, o_nxt_pc, o_trap);
                end
            end
        end
    end

    initial begin
        // ---------------- reset ----------------
        #1 i_rst_n = 1'b0;
        next_cycle();
        next_cycle();
        chk_reset_state("reset");

        push_pc(32'h0); push_pc(32'h4); push_pc(32'h8);

        // c1..c3: streaming from RESET_VEC
        next_cycle(); i_rst_n = 1'b1;
        chk_issue("c1", 1'b1, 32'h0);
        chk("c1_vld", {31'd0, o_vld}, 32'd0);
        next_cycle(); chk_issue("c2", 1'b1, 32'h4);
        chk("c2_vld", {31'd0, o_vld}, 32'd0);
        next_cycle(); chk_issue("c3", 1'b1, 32'h8);
        chk("c3_vld", {31'd0, o_vld}, 32'd1);
        chk("c3_pc", o_pc, 32'h0);
        chk("c3_nxt", o_nxt_pc, 32'h4);

        // c4..c6: hold while the response for 0x8 returns
        next_cycle(); i_hold = 1'b1; chk_issue("c4_hold", 1'b0, 32'h0);
        chk("c4_pc", o_pc, 32'h4);
        next_cycle(); chk_issue("c5_hold", 1'b0, 32'h0);
        chk("c5_pc", o_pc, 32'h4);
        next_cycle(); chk_issue("c6_hold", 1'b0, 32'h0);
        chk("c6_pc", o_pc, 32'h4);
        // c7: release, skid drains and issue resumes in the same cycle
        next_cycle(); i_hold = 1'b0; chk_issue("c7", 1'b1, 32'hC);
        chk("c7_pc", o_pc, 32'h4);
        next_cycle(); chk_issue("c8", 1'b1, 32'h10);
        chk("c8_pc", o_pc, 32'h8);

        // c9..c10: fill skid under hold, then redirect to 0x100
        next_cycle(); i_hold = 1'b1; chk_issue("c9_hold", 1'b0, 32'h0);
        chk("c9_pc", o_pc, 32'hC);
        next_cycle(); i_redirect = 1'b1; i_redirect_pc = 32'h100;
        chk_issue("c10_redir", 1'b0, 32'h0);
        push_pc(32'h100); push_pc(32'h104);
        next_cycle(); i_redirect = 1'b0; i_hold = 1'b0;
        chk_issue("c11", 1'b1, 32'h100);
        chk("c11_vld", {31'd0, o_vld}, 32'd0);
        chk("c11_inst", o_inst, NOP);
        next_cycle(); chk_issue("c12", 1'b1, 32'h104);
        chk("c12_vld", {31'd0, o_vld}, 32'd0);
        next_cycle(); chk_issue("c13", 1'b1, 32'h108);
        chk("c13_pc", o_pc, 32'h100);
        next_cycle(); chk_issue("c14", 1'b1, 32'h10C);

        // c15..c20: redirect near the top of the address space, PC wraps
        next_cycle(); i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFF8;
        chk_issue("c15_redir", 1'b0, 32'h0);
        push_pc(32'hFFFF_FFF8); push_pc(32'hFFFF_FFFC); push_pc(32'h0);
        next_cycle(); i_redirect = 1'b0; chk_issue("c16", 1'b1, 32'hFFFF_FFF8);
        next_cycle(); chk_issue("c17", 1'b1, 32'hFFFF_FFFC);
        next_cycle(); chk_issue("c18_wrap", 1'b1, 32'h0);
        next_cycle(); chk_issue("c19", 1'b1, 32'h4);
        chk("c19_pc", o_pc, 32'hFFFF_FFFC);
        chk("c19_nxt_wrap", o_nxt_pc, 32'h0);
        next_cycle(); chk_issue("c20", 1'b1, 32'h8);

        // c21..c24: misaligned redirect to 0x102
        next_cycle(); i_redirect = 1'b1; i_redirect_pc = 32'h102;
        chk_issue("c21_redir", 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        sb.push_back({32'h102, NOP, 32'h106, 1'b1});
        next_cycle(); i_redirect = 1'b0; chk_issue("c22_trap", 1'b0, 32'h0);
        chk("c22_vld", {31'd0, o_vld}, 32'd0);
        next_cycle(); chk_issue("c23_trap", 1'b0, 32'h0);
        chk("c23_vld", {31'd0, o_vld}, 32'd1);
        chk("c23_trap", {31'd0, o_trap}, 32'd1);
        chk("c23_pc", o_pc, 32'h102);
        chk("c23_nxt", o_nxt_pc, 32'h106);
        chk("c23_inst", o_inst, NOP);
        next_cycle(); chk_issue("c24_trap", 1'b0, 32'h0);
        chk("c24_vld", {31'd0, o_vld}, 32'd0);
`else
        push_pc(32'h100);
        next_cycle(); i_redirect = 1'b0; chk_issue("c22_align", 1'b1, 32'h100);
        chk("c22_vld", {31'd0, o_vld}, 32'd0);
        next_cycle(); chk_issue("c23_align", 1'b1, 32'h104);
        next_cycle(); chk_issue("c24_align", 1'b1, 32'h108);
        chk("c24_pc", o_pc, 32'h100);
        chk("c24_trap", {31'd0, o_trap}, 32'd0);
`endif

        // c25: reset in the middle of a cycle drops everything immediately
        next_cycle(); i_rst_n = 1'b0; #1;
        chk_reset_state("midrst");
        next_cycle();
        chk_reset_state("midrst_hold");
        chk("sb_drain1", sb.size(), 32'd0);

        // Halt phase: stream from 0, halt pulse while fetching 0x20
        for (int k = 0; k <= 8; k++) push_pc(32'(4 * k));
        next_cycle(); i_rst_n = 1'b1; chk_issue("h1", 1'b1, 32'h0);
        for (int k = 2; k <= 9; k++) begin
            next_cycle();
            if (k == 9) i_halt = 1'b1;
            chk_issue($sformatf("h%0d", k), 1'b1, 32'(4 * (k - 1)));
        end
        next_cycle(); i_halt = 1'b0; chk_issue("h10_halted", 1'b0, 32'h0);
        chk("h10_pc", o_pc, 32'h1C);
        next_cycle(); chk_issue("h11_halted", 1'b0, 32'h0);
        chk("h11_pc", o_pc, 32'h20);
        for (int k = 12; k <= 16; k++) begin
            next_cycle();
            chk_issue($sformatf("h%0d_halted", k), 1'b0, 32'h0);
            chk($sformatf("h%0d_vld", k), {31'd0, o_vld}, 32'd0);
        end
        chk("sb_drain2", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
